// File: rtl/draw_cmd_encoder.sv
// Packs drawing requests into 32-bit draw-command words and writes them to the draw-command FIFO.
// Define DRAW_CMD_BOUNDS_CHECK_EN to reject out-of-range requests and raise the sticky err flag.
module draw_cmd_encoder #(
    parameter logic [4:0] H_LOGIC_MAX = 5'd31,
    parameter logic [4:0] V_LOGIC_MAX = 5'd23,
    parameter logic [9:0] H_PHY_MAX   = 10'd639,
    parameter logic [8:0] V_PHY_MAX   = 9'd479,
    parameter logic [7:0] BG_COLOR    = 8'hff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_x0,
    input  logic [4:0]  req_y0,
    input  logic [4:0]  req_x1,
    input  logic [4:0]  req_y1,
    input  logic [7:0]  req_color,
    input  logic [9:0]  req_px_x,
    input  logic [8:0]  req_px_y,
    input  logic        req_px_mode,
    input  logic        ff_full,
    output logic        ff_wren,
    output logic [31:0] ff_wdat,
    output logic        busy,
    output logic [15:0] cmd_cnt,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_A = 2'd1,
        EMIT_B = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] word_b_q, word_b_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        hs;
    logic        req_bad;
    logic [31:0] word_first;
    logic [31:0] word_move;

    assign req_rdy = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign hs      = req_vld & req_rdy;
    assign ff_wren = busy & ~ff_full & rst_n;
    assign ff_wdat = wdat_q;
    assign cmd_cnt = cnt_q;
    assign err     = err_q;

    // For a move, the first word erases the old cell and the second draws the new one.
    always_comb begin
        word_first = '0;
        case (req_op)
            2'd0:    word_first = {4'h0, req_x0, req_y0, req_color, 10'b0};
            2'd1:    word_first = {4'h1, req_x0, req_y0, req_x1, req_y1, req_color};
            2'd2:    word_first = {4'h9, req_px_x, req_px_y, req_color, req_px_mode};
            default: word_first = {4'h0, req_x0, req_y0, BG_COLOR, 10'b0};
        endcase
        word_move = {4'h0, req_x1, req_y1, req_color, 10'b0};
    end

`ifdef DRAW_CMD_BOUNDS_CHECK_EN
    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            2'd0:    req_bad = (req_x0 > H_LOGIC_MAX) | (req_y0 > V_LOGIC_MAX);
            2'd1:    req_bad = (req_x0 > H_LOGIC_MAX) | (req_y0 > V_LOGIC_MAX) |
                               (req_x1 > H_LOGIC_MAX) | (req_y1 > V_LOGIC_MAX) |
                               (req_x0 > req_x1) | (req_y0 > req_y1);
            2'd2:    req_bad = (req_px_x > H_PHY_MAX) | (req_px_y > V_PHY_MAX);
            default: req_bad = (req_x0 > H_LOGIC_MAX) | (req_y0 > V_LOGIC_MAX) |
                               (req_x1 > H_LOGIC_MAX) | (req_y1 > V_LOGIC_MAX);
        endcase
    end
`else
    logic unused_limits;
    assign req_bad       = 1'b0;
    assign unused_limits = ^{H_LOGIC_MAX, V_LOGIC_MAX, H_PHY_MAX, V_PHY_MAX};
`endif

    always_comb begin
        state_d  = state_q;
        wdat_d   = wdat_q;
        word_b_d = word_b_q;
        err_d    = err_q;
        cnt_d    = cnt_q + {15'd0, ff_wren};
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        wdat_d   = word_first;
                        word_b_d = word_move;
                        state_d  = (req_op == 2'd3) ? EMIT_A : EMIT_B;
                    end
                end
            end
            EMIT_A: begin
                if (ff_wren) begin
                    wdat_d  = word_b_q;
                    state_d = EMIT_B;
                end
            end
            EMIT_B: begin
                if (ff_wren) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wdat_q   <= '0;
            word_b_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdat_q   <= wdat_d;
            word_b_q <= word_b_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_draw_cmd_encoder.sv
// Self-checking bench for draw_cmd_encoder: a queue model of expected FIFO words plus directed vectors.
module tb_draw_cmd_encoder;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_op;
    logic [4:0]  req_x0, req_y0, req_x1, req_y1;
    logic [7:0]  req_color;
    logic [9:0]  req_px_x;
    logic [8:0]  req_px_y;
    logic        req_px_mode;
    logic        ff_full;
    logic        ff_wren;
    logic [31:0] ff_wdat;
    logic        busy;
    logic [15:0] cmd_cnt;
    logic        err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = '0;
    logic        exp_err = 1'b0;
    logic [15:0] base_cnt;

    draw_cmd_encoder #(
        .H_LOGIC_MAX(5'd31),
        .V_LOGIC_MAX(5'd23),
        .H_PHY_MAX  (10'd639),
        .V_PHY_MAX  (9'd479),
        .BG_COLOR   (8'hff)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_op     (req_op),
        .req_x0     (req_x0),
        .req_y0     (req_y0),
        .req_x1     (req_x1),
        .req_y1     (req_y1),
        .req_color  (req_color),
        .req_px_x   (req_px_x),
        .req_px_y   (req_px_y),
        .req_px_mode(req_px_mode),
        .ff_full    (ff_full),
        .ff_wren    (ff_wren),
        .ff_wdat    (ff_wdat),
        .busy       (busy),
        .cmd_cnt    (cmd_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: words a request must produce, from the field layout as shifted arithmetic.
    task automatic model_request(input int unsigned op, input int unsigned x0, input int unsigned y0,
                                 input int unsigned x1, input int unsigned y1, input int unsigned color,
                                 input int unsigned pxx, input int unsigned pxy, input int unsigned mode,
                                 output bit bad);
        bad = 1'b0;
`ifdef DRAW_CMD_BOUNDS_CHECK_EN
        case (op)
            0: bad = (x0 > 31) || (y0 > 23);
            1: bad = (x0 > 31) || (y0 > 23) || (x1 > 31) || (y1 > 23) || (x0 > x1) || (y0 > y1);
            2: bad = (pxx > 639) || (pxy > 479);
            default: bad = (x0 > 31) || (y0 > 23) || (x1 > 31) || (y1 > 23);
        endcase
`endif
        if (!bad) begin
            case (op)
                0: exp_q.push_back(32'((x0 << 23) + (y0 << 18) + (color << 10)));
                1: exp_q.push_back(32'((1 << 28) + (x0 << 23) + (y0 << 18) + (x1 << 13) + (y1 << 8) + color));
                2: exp_q.push_back(32'((9 << 28) + (pxx << 18) + (pxy << 9) + (color << 1) + mode));
                default: begin
                    exp_q.push_back(32'((x0 << 23) + (y0 << 18) + (255 << 10)));
                    exp_q.push_back(32'((x1 << 23) + (y1 << 18) + (color << 10)));
                end
            endcase
        end
    endtask

    task automatic send(input int unsigned op, input int unsigned x0, input int unsigned y0,
                        input int unsigned x1, input int unsigned y1, input int unsigned color,
                        input int unsigned pxx, input int unsigned pxy, input int unsigned mode);
        bit got;
        bit bad;
        int unsigned v;
        got = 1'b0;
        @(posedge clk);
        #1;
        v = op;    req_op = v[1:0];
        v = x0;    req_x0 = v[4:0];
        v = y0;    req_y0 = v[4:0];
        v = x1;    req_x1 = v[4:0];
        v = y1;    req_y1 = v[4:0];
        v = color; req_color = v[7:0];
        v = pxx;   req_px_x = v[9:0];
        v = pxy;   req_px_y = v[8:0];
        v = mode;  req_px_mode = v[0];
        req_vld = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                got = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL handshake_timeout: req_rdy got 0, expected 1 within 50 cycles");
            req_vld = 1'b0;
        end else begin
            model_request(op, x0, y0, x1, y1, color, pxx, pxy, mode, bad);
            @(posedge clk);
            if (bad) exp_err = 1'b1;
            #1;
            req_vld = 1'b0;
        end
    endtask

    // Compare process: every live cycle, counter/err match the model and every write pops the next word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cmd_cnt", 32'(cmd_cnt), 32'(exp_cnt));
                check("err", 32'(err), 32'(exp_err));
                if (ff_wren) begin
                    check("wren_while_full", 32'(ff_full), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_write: got word %h, expected no write", ff_wdat);
                    end else begin
                        check("wdat", ff_wdat, exp_q.pop_front());
                    end
                    exp_cnt = exp_cnt + 16'd1;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req_vld = 1'b0; ff_full = 1'b0;
        req_op = '0; req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        req_color = '0; req_px_x = '0; req_px_y = '0; req_px_mode = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("rst_rdy",  32'(req_rdy), 32'd1);
        check("rst_wren", 32'(ff_wren), 32'd0);
        check("rst_wdat", ff_wdat, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt",  32'(cmd_cnt), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 5, 7, 0, 0, 8'h0f, 0, 0, 0);
        @(negedge clk);
        check("op0_wren", 32'(ff_wren), 32'd1);
        check("op0_wdat", ff_wdat, 32'h029C3C00);
        check("op0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("op0_cnt", 32'(cmd_cnt), 32'd1);
        check("op0_idle", 32'(req_rdy), 32'd1);

        send(1, 10, 10, 20, 14, 8'haa, 0, 0, 0);
        @(negedge clk);
        check("op1_wren", 32'(ff_wren), 32'd1);
        check("op1_wdat", ff_wdat, 32'h152A8EAA);

        send(2, 0, 0, 0, 0, 8'h3c, 639, 479, 1);
        @(negedge clk);
        check("op2_wren", 32'(ff_wren), 32'd1);
        send(2, 0, 0, 0, 0, 8'h01, 17, 300, 0);
        @(negedge clk);

        send(3, 3, 4, 4, 4, 8'h0f, 0, 0, 0);
        @(negedge clk);
        check("mv_a_wren", 32'(ff_wren), 32'd1);
        check("mv_a_wdat", ff_wdat, 32'h0193FC00);
        check("mv_a_rdy",  32'(req_rdy), 32'd0);
        @(negedge clk);
        check("mv_b_wren", 32'(ff_wren), 32'd1);
        check("mv_b_wdat", ff_wdat, 32'h02103C00);
        check("mv_b_rdy",  32'(req_rdy), 32'd0);
        @(negedge clk);
        check("mv_done_rdy",  32'(req_rdy), 32'd1);
        check("mv_done_wren", 32'(ff_wren), 32'd0);

        send(3, 1, 2, 30, 22, 8'h55, 0, 0, 0);
        base_cnt = exp_cnt;
        @(negedge clk);
        check("stall_first_wren", 32'(ff_wren), 32'd1);
        @(posedge clk);
        #1 ff_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wren", 32'(ff_wren), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 ff_full = 1'b0;
        @(negedge clk);
        check("stall_release_wren", 32'(ff_wren), 32'd1);
        @(negedge clk);
        check("stall_cnt_delta", 32'(cmd_cnt), 32'(base_cnt + 16'd2));

        send(0, 0, 24, 0, 0, 8'h0f, 0, 0, 0);
        @(negedge clk);
`ifdef DRAW_CMD_BOUNDS_CHECK_EN
        check("bounds_no_write", 32'(ff_wren), 32'd0);
        check("bounds_err", 32'(err), 32'd1);
        send(0, 2, 2, 0, 0, 8'h11, 0, 0, 0);
        @(negedge clk);
        check("bounds_valid_wren", 32'(ff_wren), 32'd1);
        @(negedge clk);
        check("bounds_err_sticky", 32'(err), 32'd1);
`else
        check("bounds_wren", 32'(ff_wren), 32'd1);
        check("bounds_wdat", ff_wdat, 32'h00603C00);
        check("bounds_err", 32'(err), 32'd0);
`endif
        send(2, 0, 0, 0, 0, 8'h22, 700, 3, 1);
        repeat (2) @(negedge clk);
        send(1, 20, 5, 10, 6, 8'h33, 0, 0, 0);
        repeat (2) @(negedge clk);

        @(posedge clk);
        #1 ff_full = 1'b1;
        send(0, 9, 9, 0, 0, 8'h44, 0, 0, 0);
        @(negedge clk);
        check("rstmid_stalled_wren", 32'(ff_wren), 32'd0);
        check("rstmid_stalled_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_no_write", 32'(ff_wren), 32'd0);
        @(posedge clk);
        exp_q.delete();
        exp_cnt = '0;
        exp_err = 1'b0;
        #1;
        rst_n = 1'b1;
        ff_full = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_cnt",  32'(cmd_cnt), 32'd0);
        check("rstmid_wren", 32'(ff_wren), 32'd0);
        check("rstmid_rdy",  32'(req_rdy), 32'd1);

        send(0, 31, 23, 0, 0, 8'hc3, 0, 0, 0);
        @(negedge clk);
        check("post_rst_wren", 32'(ff_wren), 32'd1);
        @(negedge clk);
        check("post_rst_cnt", 32'(cmd_cnt), 32'd1);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
